// File: rtl/fir_fifo_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_fifo_rd_ctrl_if
// Purpose  : Bundles the two buses of the FIR read sequencer:
//            - FIFO get-side pop port (req_get, nap, empty, data_get,
//              fifo_util)
//            - sample stream towards the FIR (out_data, out_valid, out_ready)
// Modports : master - the read sequencer (drives pop request and stream)
//            slave  - the FIFO + FIR environment
// Revision : 1.0 - initial release
// ============================================================================
interface fir_fifo_rd_ctrl_if #(
   parameter int DW = 32
) ();

   // FIFO get-side port
   logic          req_get;
   logic          nap;
   logic          empty;
   logic [DW-1:0] data_get;
   logic [1:0]    fifo_util;

   // Sample stream to the FIR
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;

   modport master (
      output req_get,
      output nap,
      input  empty,
      input  data_get,
      input  fifo_util,
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  req_get,
      input  nap,
      output empty,
      output data_get,
      output fifo_util,
      input  out_data,
      input  out_valid,
      output out_ready
   );

endinterface
`default_nettype wire

// File: rtl/fir_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_fifo_rd_ctrl
// Purpose  : Get-clock-domain read sequencer for the mixed-clock FIFO that
//            feeds the FIR. Pops the FIFO, discards the pipeline-priming
//            words after every start, buffers samples in a 3-entry skid
//            queue, hands them to the FIR over valid/ready, counts samples
//            per audio frame and turns fifo_util into a debounced DVFS level.
// Ports    : clk_get    - get-side clock, rising edge
//            reset      - asynchronous, active-low
//            en         - 1 = stream, 0 = stop and drain
//            bus        - FIFO pop port + FIR stream (master modport)
//            sample_cnt - samples delivered in the current frame
//            frame_done - 1-cycle pulse after the last sample of a frame
//            dvfs_level - requested get-side performance level (0..3)
//            underrun   - sticky starvation flag, cleared on restart
// Revision : 1.0 - initial release
// ============================================================================
module fir_fifo_rd_ctrl #(
   parameter int DW        = 32,
   parameter int DISCARD   = 2,
   parameter int FRAME_LEN = 44100,
   parameter int CNT_W     = 16,
   parameter int UTIL_HOLD = 64,
   parameter int HOLD_W    = 8
) (
   input  wire logic          clk_get,
   input  wire logic          reset,
   input  wire logic          en,
   fir_fifo_rd_ctrl_if.master bus,
   output logic [CNT_W-1:0]   sample_cnt,
   output logic               frame_done,
   output logic [1:0]         dvfs_level,
   output logic               underrun
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int                c_DISC_W    = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
   localparam logic [c_DISC_W-1:0] c_DISC_INIT = c_DISC_W'(DISCARD);
   localparam logic [CNT_W-1:0]  c_CNT_LAST  = CNT_W'(FRAME_LEN - 1);
   localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(UTIL_HOLD - 1);
   localparam logic [1:0]        c_Q_DEPTH   = 2'd3;

   // -------------------------------------------------------------------------
   // State machine
   // -------------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRIME = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // -------------------------------------------------------------------------
   // Datapath registers
   // -------------------------------------------------------------------------
   logic [c_DISC_W-1:0] r_disc;          // priming words still to be popped
   logic                r_inflight;      // a pop happened last edge
   logic                r_inflight_drop; // ... and that word is a priming word
   logic [DW-1:0]       r_mem [0:2];     // skid queue storage
   logic [1:0]          r_head;
   logic [1:0]          r_tail;
   logic [1:0]          r_count;
   logic [HOLD_W-1:0]   r_hold;
   logic [1:0]          r_util_prev;

   logic                w_req_get;
   logic                w_nap;
   logic                w_pop;
   logic                w_wr;
   logic                w_rd;
   logic                w_start;
   logic [2:0]          w_occupancy;
   logic                w_util_chg;
   logic                w_up;
   logic                w_dn;
   logic [HOLD_W-1:0]   w_hold_eff;

   // Ring pointer advance over the three queue slots
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Queued samples plus the one still travelling out of the FIFO; this is
   // what bounds the pop rate so the skid queue can never overflow.
   assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};

   assign w_start = (r_state == S_IDLE) && en;
   assign w_pop   = w_req_get;
   // A word arrives the cycle after its pop; priming words are simply not
   // stored, independent of the state at arrival (en may drop mid-PRIME).
   assign w_wr    = r_inflight && !r_inflight_drop;
   assign w_rd    = (r_count != 2'd0) && bus.out_ready;

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_get or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state and pop-side outputs
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_req_get   = 1'b0;
      w_nap       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_nap = 1'b1;
            if (en) begin
               w_state_nxt = S_PRIME;
            end
         end
         S_PRIME: begin
            // Priming pops need no queue space, only a remaining discard.
            w_req_get = en && !bus.empty && (r_disc != '0);
            if (!en) begin
               w_state_nxt = S_DRAIN;
            end else if (r_disc == '0) begin
               // No pop can be issued now, so the last priming word (if any)
               // is dropped on this very edge and nothing is left in flight.
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            w_req_get = en && !bus.empty && (w_occupancy < {1'b0, c_Q_DEPTH});
            if (!en) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!r_inflight && (r_count == 2'd0)) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.req_get = w_req_get;
   assign bus.nap     = w_nap;

   // -------------------------------------------------------------------------
   // Pop tracking and discard counter
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_get or negedge reset) begin
      if (!reset) begin
         r_inflight      <= 1'b0;
         r_inflight_drop <= 1'b0;
         r_disc          <= c_DISC_INIT;
      end else begin
         r_inflight      <= w_pop;
         r_inflight_drop <= w_pop && (r_state == S_PRIME);
         if (w_start) begin
            r_disc <= c_DISC_INIT;
         end else if (w_pop && (r_state == S_PRIME)) begin
            r_disc <= r_disc - 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // 3-entry skid queue
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_get or negedge reset) begin
      if (!reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_mem[2] <= '0;
         r_head   <= 2'd0;
         r_tail   <= 2'd0;
         r_count  <= 2'd0;
      end else begin
         if (w_wr) begin
            r_mem[r_tail] <= bus.data_get;
            r_tail        <= ptr_inc(r_tail);
         end
         if (w_rd) begin
            r_head <= ptr_inc(r_head);
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.out_valid = (r_count != 2'd0);
   assign bus.out_data  = r_mem[r_head];

   // -------------------------------------------------------------------------
   // Frame counter; retained across stop/start, cleared only by reset
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_get or negedge reset) begin
      if (!reset) begin
         sample_cnt <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (w_rd) begin
            if (sample_cnt == c_CNT_LAST) begin
               sample_cnt <= '0;
               frame_done <= 1'b1;
            end else begin
               sample_cnt <= sample_cnt + 1'b1;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Starvation flag
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_get or negedge reset) begin
      if (!reset) begin
         underrun <= 1'b0;
      end else if (w_start) begin
         underrun <= 1'b0;
      end else if ((r_state == S_RUN) && bus.out_ready && (r_count == 2'd0) &&
                   !r_inflight && bus.empty) begin
         underrun <= 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // DVFS filter
   // The first cycle of a new fifo_util value counts as cycle one of its run,
   // so a step happens at the end of exactly UTIL_HOLD consecutive cycles.
   // -------------------------------------------------------------------------
   assign w_util_chg = (bus.fifo_util != r_util_prev);
   assign w_up       = (bus.fifo_util == 2'd3) && (dvfs_level != 2'd3);
   assign w_dn       = (bus.fifo_util == 2'd0) && (dvfs_level != 2'd0);
   assign w_hold_eff = w_util_chg ? '0 : r_hold;

   always_ff @(posedge clk_get or negedge reset) begin
      if (!reset) begin
         r_hold      <= '0;
         r_util_prev <= 2'd0;
         dvfs_level  <= 2'd0;
      end else begin
         r_util_prev <= bus.fifo_util;
         if (!(w_up || w_dn)) begin
            r_hold <= '0;
         end else if (w_hold_eff == c_HOLD_LAST) begin
            r_hold <= '0;
            if (w_up) begin
               dvfs_level <= dvfs_level + 2'd1;
            end else begin
               dvfs_level <= dvfs_level - 2'd1;
            end
         end else begin
            r_hold <= w_hold_eff + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
